// File: rtl/exe_muldiv_unit.sv
// Multiply/divide unit for the EXE stage. It holds the architectural HI/LO
// registers, runs a single-cycle multiply and a 32-iteration restoring divide,
// and stalls the upstream pipeline while an operation is still in flight.
module exe_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  EXE_MulDivOp,
   input  logic [31:0] EXE_BusA,
   input  logic [31:0] EXE_BusB,
   input  logic        EXE_Flush,
   input  logic        EXE_Hold,
   output logic        EXE_MulDivStall,
   output logic        EXE_MulDivBusy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] op_a;       // raw BusA (multiplicand, or dividend for the divide-by-zero HI)
   logic [31:0] op_b;       // raw BusB for multiply, divisor magnitude for divide
   logic        op_signed;  // multiply is signed
   logic [31:0] q_reg;      // dividend magnitude shifting out, quotient bits shifting in
   logic [31:0] r_reg;      // partial remainder
   logic        q_neg;
   logic        r_neg;

   logic        stall, load_mul, load_div, wr_hi, wr_lo;
   logic [31:0] hi_nxt, lo_nxt;

   // Operand conditioning for divide acceptance: magnitudes for DIV, raw for DIVU.
   // The magnitude of 32'h80000000 wraps to itself, which is correct as unsigned.
   logic        sdiv;
   logic [31:0] abs_a, abs_b;
   assign sdiv  = (EXE_MulDivOp == OP_DIV);
   assign abs_a = (sdiv && EXE_BusA[31]) ? 32'd0 - EXE_BusA : EXE_BusA;
   assign abs_b = (sdiv && EXE_BusB[31]) ? 32'd0 - EXE_BusB : EXE_BusB;

   // 64-bit product; sign-extending both operands makes one multiplier serve both ops.
   logic [63:0] prod;
   assign prod = {{32{op_signed & op_a[31]}}, op_a} * {{32{op_signed & op_b[31]}}, op_b};

   // One restoring-division step: shift in the next dividend bit and try to subtract.
   logic [32:0] r_shift, r_diff;
   logic        take;
   assign r_shift = {r_reg, q_reg[31]};
   assign r_diff  = r_shift - {1'b0, op_b};
   assign take    = ~r_diff[32];

   // Sign correction applied in DONE.
   logic [31:0] q_fix, r_fix;
   assign q_fix = q_neg ? 32'd0 - q_reg : q_reg;
   assign r_fix = r_neg ? 32'd0 - r_reg : r_reg;

   // Next-state, stall and HI/LO write decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt = state;
      stall     = 1'b0;
      load_mul  = 1'b0;
      load_div  = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      hi_nxt    = HI;
      lo_nxt    = LO;
      case (state)
         S_IDLE: begin
            case (EXE_MulDivOp)
               OP_MULT, OP_MULTU: begin
                  load_mul  = 1'b1;
                  stall     = 1'b1;
                  state_nxt = S_MUL;
               end
               OP_DIV, OP_DIVU: begin
                  load_div  = 1'b1;
                  stall     = 1'b1;
                  state_nxt = S_DIV;
               end
               OP_MTHI: begin
                  wr_hi  = 1'b1;
                  hi_nxt = EXE_BusA;
               end
               OP_MTLO: begin
                  wr_lo  = 1'b1;
                  lo_nxt = EXE_BusA;
               end
               default: ;  // NONE and the reserved encoding do nothing
            endcase
         end
         S_MUL: begin
            wr_hi     = 1'b1;
            wr_lo     = 1'b1;
            hi_nxt    = prod[63:32];
            lo_nxt    = prod[31:0];
            state_nxt = EXE_Hold ? S_HOLD : S_IDLE;
         end
         S_DIV: begin
            stall = 1'b1;
            if (cnt == 6'd31) state_nxt = S_DONE;
         end
         S_DONE: begin
            wr_hi     = 1'b1;
            wr_lo     = 1'b1;
            // A zero divisor leaves the magnitude; report all-ones and the original dividend.
            hi_nxt    = (op_b == 32'd0) ? op_a : r_fix;
            lo_nxt    = (op_b == 32'd0) ? 32'hFFFF_FFFF : q_fix;
            state_nxt = EXE_Hold ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            // The finished instruction is still sitting in EXE; never restart it.
            if (!EXE_Hold) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // A squashed instruction must leave no architectural trace.
      if (EXE_Flush) begin
         state_nxt = S_IDLE;
         stall     = 1'b0;
         load_mul  = 1'b0;
         load_div  = 1'b0;
         wr_hi     = 1'b0;
         wr_lo     = 1'b0;
      end
   end

   assign EXE_MulDivStall = stall & ~rst;
   assign EXE_MulDivBusy  = (state != S_IDLE) & ~rst;

   // State, operand, iteration and HI/LO registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 6'd0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_signed <= 1'b0;
         q_reg     <= 32'd0;
         r_reg     <= 32'd0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         HI        <= 32'd0;
         LO        <= 32'd0;
      end else begin
         state <= state_nxt;
         if (wr_hi) HI <= hi_nxt;
         if (wr_lo) LO <= lo_nxt;
         if (load_mul) begin
            op_a      <= EXE_BusA;
            op_b      <= EXE_BusB;
            op_signed <= (EXE_MulDivOp == OP_MULT);
         end
         if (load_div) begin
            op_a  <= EXE_BusA;
            op_b  <= abs_b;
            q_reg <= abs_a;
            r_reg <= 32'd0;
            cnt   <= 6'd0;
            q_neg <= sdiv & (EXE_BusA[31] ^ EXE_BusB[31]);
            r_neg <= sdiv & EXE_BusA[31];
         end else if (state == S_DIV) begin
            cnt   <= cnt + 6'd1;
            r_reg <= take ? r_diff[31:0] : r_shift[31:0];
            q_reg <= {q_reg[30:0], take};
         end
      end
   end

endmodule
